// File: rtl/mul_iter_32bit_pkg.sv
// rtl/mul_iter_32bit_pkg.sv - shared definitions for the iterative 32-bit multiplier
// Purpose: word length, FSM state encodings, step count and operand-magnitude helper.
// Ports:   none (package).
package mul_iter_32bit_pkg;

   localparam int WORD_LEN   = 32;
   localparam int STEP_COUNT = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Two's-complement magnitude. -2^31 maps to 0x80000000, which is exact
   // when the result is read back as an unsigned word.
   function automatic logic [WORD_LEN-1:0] magnitude(input logic [WORD_LEN-1:0] v,
                                                     input logic             is_signed);
      return (is_signed && v[WORD_LEN-1]) ? (~v + WORD_LEN'(1)) : v;
   endfunction

endpackage

// File: rtl/Adder_CLA_32bit.sv
// rtl/Adder_CLA_32bit.sv - 32-bit carry-lookahead adder
// Purpose: s = a + b + inC, built from 4-bit lookahead groups chained by group carry.
// Ports:   a, b   - 32-bit addends
//          inC    - carry in
//          s      - 32-bit sum
//          outC   - carry out
module Adder_CLA_32bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        inC,
   output logic [31:0] s,
   output logic        outC
);

   logic [31:0] g;
   logic [31:0] p;
   logic [3:0]  gg;
   logic [3:0]  gp;
   logic        cy;
   logic        c0, c1, c2, c3, c4;

   assign g = a & b;
   assign p = a ^ b;

   always_comb begin
      s  = '0;
      gg = '0;
      gp = '0;
      cy = inC;
      c0 = 1'b0;
      c1 = 1'b0;
      c2 = 1'b0;
      c3 = 1'b0;
      c4 = 1'b0;
      for (int gi = 0; gi < 8; gi++) begin
         gg = g[gi*4 +: 4];
         gp = p[gi*4 +: 4];
         c0 = cy;
         c1 = gg[0] | (gp[0] & c0);
         c2 = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c0);
         c3 = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                    | (gp[2] & gp[1] & gp[0] & c0);
         c4 = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                    | (gp[3] & gp[2] & gp[1] & gg[0]) | ((&gp) & c0);
         s[gi*4 +: 4] = gp ^ {c3, c2, c1, c0};
         cy = c4;
      end
      outC = cy;
   end

endmodule

// File: rtl/mul_iter_32bit.sv
// rtl/mul_iter_32bit.sv - iterative shift-add 32x32 multiplier, signed/unsigned
// Purpose: 32 shift-add steps on operand magnitudes, then one sign-fix cycle.
// Ports:   clk, rst (async, active-high)
//          start, op_signed, a, b - request and operands (bit 0 = MSB)
//          busy, done             - status; done is a one-cycle pulse
//          res_hi, res_lo, ovf    - last completed 64-bit product and overflow flag
module mul_iter_32bit
   import mul_iter_32bit_pkg::*;
#(
   parameter int WORD_LEN = mul_iter_32bit_pkg::WORD_LEN
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                op_signed,
   input  logic [0:WORD_LEN-1] a,
   input  logic [0:WORD_LEN-1] b,
   output logic                busy,
   output logic                done,
   output logic [0:WORD_LEN-1] res_hi,
   output logic [0:WORD_LEN-1] res_lo,
   output logic                ovf
);

   localparam int CNT_W = $clog2(STEP_COUNT);

   state_t                state;
   state_t                state_nxt;
   logic [CNT_W-1:0]      cnt;
   logic [WORD_LEN-1:0]   mcand;
   logic [WORD_LEN-1:0]   mplier;
   logic [WORD_LEN-1:0]   prod_hi;
   logic [WORD_LEN-1:0]   prod_lo;
   logic                  res_sign;
   logic                  sgn_mode;
   logic [WORD_LEN-1:0]   add_b;
   logic [WORD_LEN-1:0]   add_s;
   logic                  add_c;
   logic [2*WORD_LEN-1:0] fixed;
   logic                  ovf_nxt;
   logic                  last_step;
   logic                  accept;

   assign last_step = (cnt == CNT_W'(STEP_COUNT - 1));
   assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));

   // Partial product: add the multiplicand only when the current multiplier LSB is set.
   assign add_b = mplier[0] ? mcand : '0;

   Adder_CLA_32bit u_add (
      .a    (prod_hi),
      .b    (add_b),
      .inC  (1'b0),
      .s    (add_s),
      .outC (add_c)
   );

   // Apply the result sign to the unsigned magnitude product.
   assign fixed = res_sign ? (~{prod_hi, prod_lo} + (2*WORD_LEN)'(1)) : {prod_hi, prod_lo};

   // Signed fit: the high word must be a pure sign extension of the low word.
   assign ovf_nxt = sgn_mode ? (fixed[2*WORD_LEN-1:WORD_LEN] != {WORD_LEN{fixed[WORD_LEN-1]}})
                             : (fixed[2*WORD_LEN-1:WORD_LEN] != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_RUN;
         ST_RUN: begin
            busy = 1'b1;
            if (last_step) state_nxt = ST_FIX;
         end
         ST_FIX: begin
            busy      = 1'b1;
            state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = start ? ST_RUN : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         prod_hi  <= '0;
         prod_lo  <= '0;
         res_sign <= 1'b0;
         sgn_mode <= 1'b0;
         res_hi   <= '0;
         res_lo   <= '0;
         ovf      <= 1'b0;
      end else if (accept) begin
         mcand    <= magnitude(a, op_signed);
         mplier   <= magnitude(b, op_signed);
         res_sign <= op_signed & (a[0] ^ b[0]);
         sgn_mode <= op_signed;
         prod_hi  <= '0;
         prod_lo  <= '0;
         cnt      <= '0;
      end else if (state == ST_RUN) begin
         // Shift right with the adder carry landing in the top of the high word.
         prod_hi <= {add_c, add_s[WORD_LEN-1:1]};
         prod_lo <= {add_s[0], prod_lo[WORD_LEN-1:1]};
         mplier  <= mplier >> 1;
         cnt     <= cnt + CNT_W'(1);
      end else if (state == ST_FIX) begin
         res_hi <= fixed[2*WORD_LEN-1:WORD_LEN];
         res_lo <= fixed[WORD_LEN-1:0];
         ovf    <= ovf_nxt;
      end
   end

endmodule
